cache_tag_hit_unit: RTL and testbench
=====================================

Name: cache_tag_hit_unit

Overview:
- Parametrised, registered successor to the PPN/CPN hit comparator.
- Holds a WAYS-way, 2^IDX_W-set tag store of {shadow, tag} entries with valid bits.
- Compares a lookup tag against every way and registers per-way active-low hits.
- On a miss, requests and allocates a fill through a handshake; also provides a sequential flush.
- Sits between the MMU page-number path (PPN_23_10) and the cache data RAM control.

Parameters:
- TAG_W, 14, tag width in bits (PPN bits 23:10).
- WAYS, 2, number of ways (1..8).
- IDX_W, 6, set index width; 2^IDX_W sets.
- Localparam WAY_W = max(1, clog2(WAYS)).

Ports:
- sysclk  in  1  system clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- LK_REQ  in  1  lookup request; sampled only in IDLE.
- LK_IDX  in  IDX_W  set index.
- LK_TAG  in  TAG_W  physical page number to compare.
- LSHADOW  in  1  shadow-space qualifier; stored and compared as tag bit TAG_W.
- FMISS  in  1  force miss for this lookup.
- CON_n  in  1  cache on, active low; 1 means uncached lookup.
- INV  in  1  flush request; sampled only in IDLE.
- FILL_ACK  in  1  fill done; valid only while FILL_REQ=1.
- HIT_n  out  WAYS  per-way hit, active low, registered.
- HIT_VALID  out  1  one-cycle strobe qualifying HIT_n/MISS.
- MISS  out  1  miss result, qualified by HIT_VALID.
- FILL_REQ  out  1  fill request, level, held until FILL_ACK.
- FILL_WAY  out  WAY_W  victim way for the pending fill.
- BUSY  out  1  1 whenever the FSM is not IDLE.

Behaviour:
- Reset values (async, sys_rst_n=0):
  - HIT_n all ones; HIT_VALID, MISS, FILL_REQ, BUSY = 0; FILL_WAY = 0.
  - All valid bits cleared; round-robin pointer = 0; FSM = IDLE.
  - Tag contents are don't-care after reset.
- FSM states: IDLE, RESULT, FILL_WAIT, FLUSH.
- IDLE:
  - INV=1 → FLUSH; INV wins over a simultaneous LK_REQ, which is dropped.
  - Else LK_REQ=1 → latch LK_IDX, LK_TAG, LSHADOW, FMISS, CON_n → RESULT.
- RESULT (one cycle; latency is 1 clock from the LK_REQ edge to the HIT_VALID edge):
  - HIT_VALID=1.
  - HIT_n[w]=0 iff valid[w][idx], stored tag == LK_TAG, stored shadow == LSHADOW, FMISS=0 and CON_n=0.
  - Multiple matching ways: all assert, no priority (the bench flags this as an error).
  - CON_n=1: HIT_n all ones, MISS=0, no fill → IDLE.
  - FMISS=1 (CON_n=0): HIT_n all ones, MISS=1, no fill → IDLE.
  - Genuine miss: MISS=1 → FILL_WAIT; otherwise → IDLE.
- Victim choice (latched on entering FILL_WAIT):
  - Lowest-numbered invalid way in the set.
  - If all ways are valid, the round-robin pointer.
  - The pointer advances, modulo WAYS, only when a valid way is replaced.
- FILL_WAIT:
  - FILL_REQ=1 and FILL_WAY stable.
  - On FILL_ACK=1: write {LSHADOW, LK_TAG} and set the valid bit at the latched idx/way → IDLE. FILL_REQ is 0 from the next cycle.
  - LK_REQ and INV are ignored.
  - FILL_ACK outside FILL_WAIT is ignored.
- FLUSH:
  - Clears valid bits of set k on cycle k, k = 0..2^IDX_W-1, then → IDLE.
  - BUSY stays 1 throughout.
- Back-to-back lookups: earliest next LK_REQ acceptance is the cycle after RESULT (one lookup per 2 cycles).
- Reset mid-fill or mid-flush: the operation is abandoned and state returns to reset values.

Optional Feature:
- Macro: CACHE_HIT_STATS_EN.
- With the macro defined, two extra output ports are present:
  - HIT_CNT 16 bits, incremented on each HIT_VALID cycle with any HIT_n low.
  - MISS_CNT 16 bits, incremented on each genuine miss (fill started; FMISS and CON_n misses excluded).
  - Both counters saturate at 16'hFFFF.
  - Both counters clear on reset and on entering FLUSH.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup idx=5, tag=14'h0123, CON_n=0 → cycle+1: HIT_VALID=1, MISS=1, HIT_n=2'b11; FILL_REQ=1, FILL_WAY=0. FILL_ACK → FILL_REQ=0 next cycle.
- Repeat the same lookup → HIT_n=2'b10, MISS=0, no FILL_REQ. Repeat with LSHADOW flipped → miss, FILL_WAY=1.
- Fill set 5 ways 0/1, then miss with a third tag → FILL_WAY=0 (rr), pointer→1. Next conflicting miss → FILL_WAY=1.
- Hit-able lookup with FMISS=1 → MISS=1, HIT_n=2'b11, no FILL_REQ. With CON_n=1 → MISS=0, HIT_n=2'b11.
- INV and LK_REQ in the same cycle → BUSY=1 for 64 cycles, no HIT_VALID. Afterwards the prior hit tag misses.
- Assert sys_rst_n=0 during FILL_WAIT → FILL_REQ=0 immediately (async). Afterwards the prior tag misses. With CACHE_HIT_STATS_EN, HIT_CNT=0.

Source files
------------

// File: rtl/cache_tag_hit_unit_if.sv
// Lookup/fill handshake bundle for cache_tag_hit_unit.
// HIT_CNT/MISS_CNT exist only when CACHE_HIT_STATS_EN is defined.
interface cache_tag_hit_unit_if #(
    parameter int TAG_W = 14,
    parameter int WAYS  = 2,
    parameter int IDX_W = 6
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic             LK_REQ;
    logic [IDX_W-1:0] LK_IDX;
    logic [TAG_W-1:0] LK_TAG;
    logic             LSHADOW;
    logic             FMISS;
    logic             CON_n;
    logic             INV;
    logic             FILL_ACK;
    logic [WAYS-1:0]  HIT_n;
    logic             HIT_VALID;
    logic             MISS;
    logic             FILL_REQ;
    logic [WAY_W-1:0] FILL_WAY;
    logic             BUSY;
`ifdef CACHE_HIT_STATS_EN
    logic [15:0]      HIT_CNT;
    logic [15:0]      MISS_CNT;
`endif

    modport master (
        output LK_REQ, LK_IDX, LK_TAG, LSHADOW, FMISS, CON_n, INV, FILL_ACK,
        input  HIT_n, HIT_VALID, MISS, FILL_REQ, FILL_WAY, BUSY
`ifdef CACHE_HIT_STATS_EN
        , input HIT_CNT, MISS_CNT
`endif
    );

    modport slave (
        input  LK_REQ, LK_IDX, LK_TAG, LSHADOW, FMISS, CON_n, INV, FILL_ACK,
        output HIT_n, HIT_VALID, MISS, FILL_REQ, FILL_WAY, BUSY
`ifdef CACHE_HIT_STATS_EN
        , output HIT_CNT, MISS_CNT
`endif
    );
endinterface

// File: rtl/cache_tag_hit_unit.sv
// Registered WAYS-way tag store with per-way active-low hits, fill handshake and sequential flush.
// Optional hit/miss counters are enabled by defining CACHE_HIT_STATS_EN.
module cache_tag_hit_unit #(
    parameter int TAG_W = 14,
    parameter int WAYS  = 2,
    parameter int IDX_W = 6
) (
    input logic                sysclk,
    input logic                sys_rst_n,
    cache_tag_hit_unit_if.slave bus
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_RESULT, S_FILL_WAIT, S_FLUSH} state_t;

    state_t                       state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]    valid_q, valid_d;
    logic [TAG_W:0]               tag_mem [SETS][WAYS];
    logic [IDX_W-1:0]             idx_q, idx_d, fl_idx_q, fl_idx_d;
    logic [TAG_W:0]               ltag_q, ltag_d;
    logic                         fmiss_q, fmiss_d, con_n_q, con_n_d;
    logic [WAYS-1:0]              hit_n_q, hit_n_d;
    logic                         hit_valid_q, hit_valid_d, miss_q, miss_d;
    logic                         fill_req_q, fill_req_d, busy_q, busy_d;
    logic                         repl_valid_q, repl_valid_d;
    logic [WAY_W-1:0]             fill_way_q, fill_way_d, rr_q, rr_d;
    logic [WAYS-1:0]              raw_hit, hit_vec;
    logic [WAY_W-1:0]             victim;
    logic                         found_inv, genuine_miss, tag_we;

    // Compare the latched lookup against the addressed set; shadow is the tag MSB.
    always_comb begin
        victim    = rr_q;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++)
            raw_hit[w] = valid_q[idx_q][w] && (tag_mem[idx_q][w] == ltag_q);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_q][w]) begin
                victim    = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
        hit_vec      = raw_hit & {WAYS{!fmiss_q && !con_n_q}};
        genuine_miss = !con_n_q && !fmiss_q && !(|raw_hit);
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        idx_d        = idx_q;
        fl_idx_d     = fl_idx_q;
        ltag_d       = ltag_q;
        fmiss_d      = fmiss_q;
        con_n_d      = con_n_q;
        hit_n_d      = '1;
        hit_valid_d  = 1'b0;
        miss_d       = 1'b0;
        fill_req_d   = fill_req_q;
        fill_way_d   = fill_way_q;
        repl_valid_d = repl_valid_q;
        rr_d         = rr_q;
        tag_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.INV) begin
                    state_d  = S_FLUSH;
                    fl_idx_d = '0;
                end else if (bus.LK_REQ) begin
                    idx_d   = bus.LK_IDX;
                    ltag_d  = {bus.LSHADOW, bus.LK_TAG};
                    fmiss_d = bus.FMISS;
                    con_n_d = bus.CON_n;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                hit_valid_d = 1'b1;
                hit_n_d     = ~hit_vec;
                miss_d      = (!con_n_q && fmiss_q) || genuine_miss;
                if (genuine_miss) begin
                    state_d      = S_FILL_WAIT;
                    fill_req_d   = 1'b1;
                    fill_way_d   = victim;
                    repl_valid_d = !found_inv;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL_WAIT: begin
                if (bus.FILL_ACK) begin
                    tag_we                      = 1'b1;
                    valid_d[idx_q][fill_way_q]  = 1'b1;
                    fill_req_d                  = 1'b0;
                    state_d                     = S_IDLE;
                    if (repl_valid_q)
                        rr_d = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + 1'b1;
                end
            end
            S_FLUSH: begin
                valid_d[fl_idx_q] = '0;
                fl_idx_d          = fl_idx_q + 1'b1;
                if (fl_idx_q == '1)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            idx_q        <= '0;
            fl_idx_q     <= '0;
            ltag_q       <= '0;
            fmiss_q      <= 1'b0;
            con_n_q      <= 1'b0;
            hit_n_q      <= '1;
            hit_valid_q  <= 1'b0;
            miss_q       <= 1'b0;
            fill_req_q   <= 1'b0;
            fill_way_q   <= '0;
            repl_valid_q <= 1'b0;
            rr_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            idx_q        <= idx_d;
            fl_idx_q     <= fl_idx_d;
            ltag_q       <= ltag_d;
            fmiss_q      <= fmiss_d;
            con_n_q      <= con_n_d;
            hit_n_q      <= hit_n_d;
            hit_valid_q  <= hit_valid_d;
            miss_q       <= miss_d;
            fill_req_q   <= fill_req_d;
            fill_way_q   <= fill_way_d;
            repl_valid_q <= repl_valid_d;
            rr_q         <= rr_d;
            busy_q       <= busy_d;
        end
    end

    // Tag payload needs no reset: the valid bits gate every use.
    always_ff @(posedge sysclk) begin
        if (tag_we)
            tag_mem[idx_q][fill_way_q] <= ltag_q;
    end

    assign bus.HIT_n     = hit_n_q;
    assign bus.HIT_VALID = hit_valid_q;
    assign bus.MISS      = miss_q;
    assign bus.FILL_REQ  = fill_req_q;
    assign bus.FILL_WAY  = fill_way_q;
    assign bus.BUSY      = busy_q;

`ifdef CACHE_HIT_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_IDLE && bus.INV) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (state_q == S_RESULT) begin
            if (|hit_vec && hit_cnt_q != 16'hFFFF)
                hit_cnt_d = hit_cnt_q + 16'd1;
            if (genuine_miss && miss_cnt_q != 16'hFFFF)
                miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.HIT_CNT  = hit_cnt_q;
    assign bus.MISS_CNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_tag_hit_unit.sv
// Scoreboard bench for cache_tag_hit_unit: a behavioural tag-store model predicts each lookup result.
// Define CACHE_HIT_STATS_EN for both RTL and bench to also check the counters.
module tb_cache_tag_hit_unit;
    localparam int TAG_W = 14;
    localparam int WAYS  = 2;
    localparam int IDX_W = 6;
    localparam int SETS  = 1 << IDX_W;
    localparam int WAY_W = 1;

    logic sysclk    = 1'b0;
    logic sys_rst_n = 1'b1;
    always #5 sysclk = ~sysclk;

    cache_tag_hit_unit_if #(.TAG_W(TAG_W), .WAYS(WAYS), .IDX_W(IDX_W)) bus ();

    cache_tag_hit_unit #(.TAG_W(TAG_W), .WAYS(WAYS), .IDX_W(IDX_W)) dut (
        .sysclk   (sysclk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [WAYS-1:0]  hit_n;
        logic             miss;
        logic             fill;
        logic [WAY_W-1:0] way;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_vec = 0;
    int   n_err = 0;

    logic             m_valid [SETS][WAYS];
    logic [TAG_W:0]   m_tag   [SETS][WAYS];
    int               m_rr;
    int               m_hits, m_miss;
    logic [IDX_W-1:0] p_idx;
    logic [WAY_W-1:0] p_way;
    logic [TAG_W:0]   p_tag;
    bit               p_repl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    always @(negedge sysclk) begin
        if (sys_rst_n && bus.HIT_VALID) begin
            if (sb.size() == 0) begin
                chk("spurious_hit_valid", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("hit_n", 32'(bus.HIT_n), 32'(e_mon.hit_n));
                chk("miss", 32'(bus.MISS), 32'(e_mon.miss));
                chk("fill_req", 32'(bus.FILL_REQ), 32'(e_mon.fill));
                if (e_mon.fill) chk("fill_way", 32'(bus.FILL_WAY), 32'(e_mon.way));
                chk("multi_hit", 32'($countones(~bus.HIT_n) > 1), 32'd0);
            end
        end
    end

    task automatic fill_ack();
        repeat (2) @(negedge sysclk);
        #1;
        chk("fill_hold", {31'd0, bus.FILL_REQ}, 32'd1);
        chk("fill_way_stable", 32'(bus.FILL_WAY), 32'(p_way));
        bus.FILL_ACK = 1'b1;
        @(posedge sysclk);
        #1;
        bus.FILL_ACK = 1'b0;
        chk("fill_req_drop", {31'd0, bus.FILL_REQ}, 32'd0);
        m_valid[p_idx][p_way] = 1'b1;
        m_tag[p_idx][p_way]   = p_tag;
        if (p_repl) m_rr = (m_rr + 1) % WAYS;
    endtask

    task automatic lookup(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input bit sh, input bit fm, input bit cn, input bit ack);
        exp_t e;
        bit   raw;
        int   inv_w;
        e.hit_n = '1;
        raw     = 1'b0;
        inv_w   = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[idx][w] && m_tag[idx][w] == {sh, tag}) begin
                raw = 1'b1;
                if (!fm && !cn) e.hit_n[w] = 1'b0;
            end
            if (!m_valid[idx][w] && inv_w < 0) inv_w = w;
        end
        e.miss = !cn && (fm || !raw);
        e.fill = !cn && !fm && !raw;
        e.way  = (inv_w >= 0) ? WAY_W'(inv_w) : WAY_W'(m_rr);
        if (e.hit_n != '1) m_hits++;
        if (e.fill) m_miss++;
        sb.push_back(e);
        @(negedge sysclk);
        bus.LK_REQ  = 1'b1;
        bus.LK_IDX  = idx;
        bus.LK_TAG  = tag;
        bus.LSHADOW = sh;
        bus.FMISS   = fm;
        bus.CON_n   = cn;
        @(negedge sysclk);
        bus.LK_REQ = 1'b0;
        chk("busy_in_result", {31'd0, bus.BUSY}, 32'd1);
        @(negedge sysclk);
        #1;
        chk("result_latency", 32'(sb.size()), 32'd0);
        sb.delete();
        if (e.fill) begin
            p_idx  = idx;
            p_way  = e.way;
            p_tag  = {sh, tag};
            p_repl = (inv_w < 0);
            if (ack) fill_ack();
        end
    endtask

    initial begin
        int busy_cnt;
        logic [TAG_W-1:0] rt;
        bus.LK_REQ = 0; bus.LK_IDX = '0; bus.LK_TAG = '0; bus.LSHADOW = 0;
        bus.FMISS = 0; bus.CON_n = 0; bus.INV = 0; bus.FILL_ACK = 0;
        model_clear();
        m_rr = 0;
        #2 sys_rst_n = 1'b0;
        #10;
        chk("rst_hit_n", 32'(bus.HIT_n), 32'h3);
        chk("rst_hit_valid", {31'd0, bus.HIT_VALID}, 32'd0);
        chk("rst_miss", {31'd0, bus.MISS}, 32'd0);
        chk("rst_fill_req", {31'd0, bus.FILL_REQ}, 32'd0);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_fill_way", 32'(bus.FILL_WAY), 32'd0);
        repeat (2) @(negedge sysclk);
        sys_rst_n = 1'b1;

        lookup(6'd5, 14'h0123, 0, 0, 0, 1);   // cold miss, way 0
        lookup(6'd5, 14'h0123, 0, 0, 0, 1);   // hit way 0
        lookup(6'd5, 14'h0123, 1, 0, 0, 1);   // shadow differs, way 1
        lookup(6'd5, 14'h0456, 0, 0, 0, 1);   // set full, rr -> way 0
        lookup(6'd5, 14'h0789, 0, 0, 0, 1);   // rr -> way 1
        lookup(6'd5, 14'h0789, 0, 1, 0, 1);   // forced miss
        lookup(6'd5, 14'h0789, 0, 0, 1, 1);   // uncached
        lookup(6'd5, 14'h0789, 0, 0, 0, 1);   // hit way 1
        lookup(6'd5, 14'h0456, 0, 0, 0, 1);   // hit way 0

        for (int i = 0; i < 6; i++) begin
            rt = 14'($urandom_range(0, 16383));
            lookup(6'($urandom_range(0, SETS - 1)), rt, 1'($urandom_range(0, 1)), 0, 0, 1);
            lookup(6'd9, rt, 0, 0, 0, 1);
            lookup(6'd9, rt, 0, 0, 0, 1);
        end

`ifdef CACHE_HIT_STATS_EN
        chk("hit_cnt", 32'(bus.HIT_CNT), 32'(m_hits));
        chk("miss_cnt", 32'(bus.MISS_CNT), 32'(m_miss));
`endif

        // Flush with a colliding lookup that must be dropped.
        @(negedge sysclk);
        bus.INV = 1'b1; bus.LK_REQ = 1'b1; bus.LK_IDX = 6'd5; bus.LK_TAG = 14'h0789;
        @(negedge sysclk);
        bus.INV = 1'b0; bus.LK_REQ = 1'b0;
        model_clear();
        busy_cnt = 32'(bus.BUSY);
        for (int i = 0; i < 79; i++) begin
            @(negedge sysclk);
            busy_cnt += 32'(bus.BUSY);
        end
        chk("flush_busy_cycles", 32'(busy_cnt), 32'd64);
`ifdef CACHE_HIT_STATS_EN
        chk("flush_hit_cnt", 32'(bus.HIT_CNT), 32'd0);
`endif
        lookup(6'd5, 14'h0789, 0, 0, 0, 1);   // flushed: must miss

        // Reset while a fill is outstanding.
        lookup(6'd5, 14'h0AAA, 0, 0, 0, 0);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_fill_req", {31'd0, bus.FILL_REQ}, 32'd0);
        chk("rst_mid_fill_busy", {31'd0, bus.BUSY}, 32'd0);
        model_clear();
        m_rr = 0;
        @(negedge sysclk);
        sys_rst_n = 1'b1;
`ifdef CACHE_HIT_STATS_EN
        chk("rst_hit_cnt", 32'(bus.HIT_CNT), 32'd0);
`endif
        lookup(6'd5, 14'h0789, 0, 0, 0, 1);   // valid bits gone: miss, way 0
        lookup(6'd5, 14'h0789, 0, 0, 0, 1);

        repeat (3) @(negedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
